// File: rtl/game_tick_pkg.sv
// Shared types and effective-period arithmetic for the multi-channel game tick generator.
// GAME_TICK_SPEEDUP_EN enables level-based shortening of channel 0's period.
package game_tick_pkg;

   typedef enum logic [1:0] {
      RUN,
      PAUSE,
      STEP
   } tick_state_e;

   localparam int unsigned MIN_EFF = 1;

   // Wide enough to hold level*SPEED_STEP exactly for CNT_W+LEVEL_W up to 64 bits
   localparam int WIDE_W = 64;
   typedef logic [WIDE_W-1:0] wide_t;

`ifdef GAME_TICK_SPEEDUP_EN
   localparam bit SPEEDUP_EN = 1'b1;
`else
   localparam bit SPEEDUP_EN = 1'b0;
`endif

   // Speed-up subtracts whole level steps and never drops below min_period or MIN_EFF
   function automatic wide_t eff_period(input wide_t per,
                                        input wide_t level,
                                        input logic  is_ch0,
                                        input wide_t speed_step,
                                        input wide_t min_period);
      wide_t dec;
      wide_t eff;
      dec = level * speed_step;
      eff = (per < wide_t'(MIN_EFF)) ? wide_t'(MIN_EFF) : per;
      if (SPEEDUP_EN && is_ch0) begin
         eff = (per > dec) ? (per - dec) : '0;
         if (eff < min_period) begin
            eff = min_period;
         end
         if (eff < wide_t'(MIN_EFF)) begin
            eff = wide_t'(MIN_EFF);
         end
      end
      return eff;
   endfunction

endpackage

// File: rtl/tick_channel.sv
// One down-counting tick channel: owns its period register, counter, reload mux and tick flop.
// Speed-up (GAME_TICK_SPEEDUP_EN) is resolved inside eff_period; IS_CH0 selects who gets it.
module tick_channel
   import game_tick_pkg::*;
#(
   parameter int          CNT_W          = 32,
   parameter int          LEVEL_W        = 4,
   parameter int unsigned DEFAULT_PERIOD = 25_000_000,
   parameter int unsigned MIN_PERIOD     = 1_000_000,
   parameter int unsigned SPEED_STEP     = 1_000_000,
   parameter bit          IS_CH0         = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               advance,
   input  logic               force_tick,
   input  logic               sync,
   input  logic               wr_en,
   input  logic [CNT_W-1:0]   wr_period,
   input  logic [LEVEL_W-1:0] level,
   output logic               tick
);

   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEF_PER = CNT_W'(DEFAULT_PERIOD);

   logic [CNT_W-1:0] per;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] per_next;
   logic [CNT_W-1:0] reload_val;
   logic [CNT_W-1:0] rst_val;
   logic             expired;

   function automatic logic [CNT_W-1:0] reload_of(input logic [CNT_W-1:0]   p,
                                                  input logic [LEVEL_W-1:0] lvl);
      wide_t e;
      e = eff_period(wide_t'(p), wide_t'(lvl), IS_CH0,
                     wide_t'(SPEED_STEP), wide_t'(MIN_PERIOD));
      return CNT_W'(e - wide_t'(1));
   endfunction

   // Reloads always use the period that will be in force after this edge, so a
   // write landing with an expiry or a sync already counts with the new value
   always_comb begin
      per_next   = wr_en ? wr_period : per;
      reload_val = reload_of(per_next, level);
      rst_val    = reload_of(DEF_PER, level);
      expired    = (cnt == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         per  <= DEF_PER;
         cnt  <= rst_val;
         tick <= 1'b0;
      end else begin
         per <= per_next;
         if (sync) begin
            cnt  <= reload_val;
            tick <= 1'b0;
         end else if (force_tick) begin
            cnt  <= reload_val;
            tick <= 1'b1;
         end else if (advance) begin
            tick <= expired;
            cnt  <= (expired || wr_en) ? reload_val : (cnt - ONE);
         end else begin
            tick <= 1'b0;
            if (wr_en) begin
               cnt <= reload_val;
            end
         end
      end
   end

endmodule

// File: rtl/game_tick_gen.sv
// Multi-channel game tick generator: run/pause/step FSM, period-write decode and sync fan-out.
// Define GAME_TICK_SPEEDUP_EN to let level shorten channel 0's period; otherwise level is ignored.
module game_tick_gen
   import game_tick_pkg::*;
#(
   parameter int          CHANNELS       = 2,
   parameter int          CH_W           = 1,
   parameter int          CNT_W          = 32,
   parameter int unsigned DEFAULT_PERIOD = 25_000_000,
   parameter int unsigned MIN_PERIOD     = 1_000_000,
   parameter int unsigned SPEED_STEP     = 1_000_000,
   parameter int          LEVEL_W        = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
   input  logic                step,
   input  logic                sync,
   input  logic [LEVEL_W-1:0]  level,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CH_W-1:0]     cfg_chan,
   input  logic [CNT_W-1:0]    cfg_period,
   output logic [CHANNELS-1:0] tick,
   output logic                paused
);

   tick_state_e          state;
   tick_state_e          state_next;
   logic                 advance;
   logic                 force_tick;
   logic                 cfg_accept;
   logic [LEVEL_W-1:0]   level_eff;
   logic [CHANNELS-1:0]  wr_en;

`ifdef GAME_TICK_SPEEDUP_EN
   assign level_eff = level;
`else
   logic unused_level;
   assign level_eff    = '0;
   assign unused_level = ^level;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   // Counting stops on the very edge run drops; run always wins over step
   always_comb begin
      state_next = state;
      advance    = 1'b0;
      force_tick = 1'b0;
      case (state)
         RUN: begin
            if (run) begin
               advance = 1'b1;
            end else begin
               state_next = PAUSE;
            end
         end
         PAUSE: begin
            if (run) begin
               state_next = RUN;
            end else if (step) begin
               state_next = STEP;
            end
         end
         STEP: begin
            force_tick = 1'b1;
            state_next = run ? RUN : PAUSE;
         end
         default: begin
            state_next = RUN;
         end
      endcase
   end

   assign cfg_ready  = (state != STEP);
   assign paused     = (state != RUN);
   assign cfg_accept = cfg_valid && cfg_ready;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      assign wr_en[c] = cfg_accept && (32'(cfg_chan) == 32'(c));

      tick_channel #(
         .CNT_W          (CNT_W),
         .LEVEL_W        (LEVEL_W),
         .DEFAULT_PERIOD (DEFAULT_PERIOD),
         .MIN_PERIOD     (MIN_PERIOD),
         .SPEED_STEP     (SPEED_STEP),
         .IS_CH0         (c == 0)
      ) u_chan (
         .clk        (clk),
         .rst        (rst),
         .advance    (advance),
         .force_tick (force_tick),
         .sync       (sync),
         .wr_en      (wr_en[c]),
         .wr_period  (cfg_period),
         .level      (level_eff),
         .tick       (tick[c])
      );
   end

endmodule
